// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
//
// Purpose:
//    Bundles the sample tick, the raw button line and the two conditioned
//    outputs of button_debouncer so that the debouncer and whatever drives it
//    (the board input path, or a bench) share one connection object.
//
// Signals:
//    ena       sample tick; the stability counter advances only when high
//    in        raw, asynchronous, bouncy button level
//    out       debounced level, feeds the downstream edge detector
//    bouncing  high while a candidate transition is being qualified
//
// Modports:
//    master    the side that owns the button (drives ena/in, observes outputs)
//    slave     the debouncer itself
// -----------------------------------------------------------------------------
interface button_debouncer_if;

   logic ena;
   logic in;
   logic out;
   logic bouncing;

   modport master (
      output ena,
      output in,
      input  out,
      input  bouncing
   );

   modport slave (
      input  ena,
      input  in,
      output out,
      output bouncing
   );

endinterface : button_debouncer_if

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//    Turns one raw push-button / encoder line into a clean level for the
//    etch-a-sketch input path. A physical press produces exactly one rising
//    and one falling transition on bus.out, so the edge detector downstream
//    sees one positive_edge and one negative_edge per press.
//
//    Pipeline:
//       bus.in -> 2-flop synchronizer -> in_s -> 4-state Moore FSM -> outputs
//    A candidate level change is only accepted once in_s has held the new
//    level for BOUNCE_TICKS ena-qualified cycles after the wait state is
//    entered; any reversal of in_s during that window throws the candidate
//    away and qualification starts over.
//
//    Latency with ena tied high: if edge 0 is the first clock edge that
//    samples the new level on bus.in, bus.out follows at edge 2+BOUNCE_TICKS.
//
// Parameters:
//    BOUNCE_TICKS  ena-qualified cycles a new level must persist (>= 1)
//    COUNT_W       stability counter width, derived from BOUNCE_TICKS
//
// Ports:
//    clk           system clock, all state on the rising edge
//    rst           asynchronous, active-low reset
//    bus.ena       sample tick (slave input)
//    bus.in        raw button level (slave input)
//    bus.out       debounced level (slave output)
//    bus.bouncing  qualification in progress (slave output)
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int BOUNCE_TICKS = 4,
   parameter int COUNT_W      = $clog2(BOUNCE_TICKS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   button_debouncer_if.slave   bus
);

   // --------------------------------------------------------------------------
   // State encoding. Bit 1 is the debounced level and bit 0 marks the wait
   // states, so both outputs are straight register bits with no decode logic
   // and therefore cannot glitch.
   // --------------------------------------------------------------------------
   localparam logic [1:0] S_LOW  = 2'b00;
   localparam logic [1:0] S_RISE = 2'b01;
   localparam logic [1:0] S_HIGH = 2'b10;
   localparam logic [1:0] S_FALL = 2'b11;

   // Terminal count: the wait state is left on the ena cycle that finds the
   // counter here, giving BOUNCE_TICKS ena-qualified cycles in total.
   localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(BOUNCE_TICKS - 1);

   logic [1:0]         sync_q;
   logic               in_s;

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   // --------------------------------------------------------------------------
   // Two-flop synchronizer. Nothing sits between the flops so the first stage
   // has a full cycle to resolve metastability before the FSM looks at it.
   // --------------------------------------------------------------------------
   // NOTE: the synchronizer flops get a reset too. Leaving them unreset would
   // let stale pre-reset button state leak into the FSM on the first edges
   // after release, and a mid-operation reset must restart qualification from
   // the raw pin with the full latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         // NOTE: every clocked assignment is non-blocking so that sync_q[1]
         // picks up the old sync_q[0], not the value just written this edge.
         sync_q <= {sync_q[0], bus.in};
      end
   end

   assign in_s = sync_q[1];

   // --------------------------------------------------------------------------
   // Next-state and counter logic.
   //
   // Order inside each wait state matters: an in_s reversal is tested first,
   // so a bounce always wins over both the tick and the terminal count in the
   // same cycle. The counter is cleared on every state change so each wait
   // starts from zero, and it only ever reaches COUNT_LAST, so it cannot wrap.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: both outputs of this block get a default before the case so
      // every path assigns them and no latch is inferred.
      state_d = state_q;
      count_d = count_q;

      case (state_q)
         S_LOW: begin
            if (in_s) begin
               state_d = S_RISE;
               count_d = '0;
            end
         end

         S_RISE: begin
            if (!in_s) begin
               // Bounce back to the old level: abandon this candidate.
               state_d = S_LOW;
               count_d = '0;
            end else if (bus.ena) begin
               if (count_q == COUNT_LAST) begin
                  state_d = S_HIGH;
                  count_d = '0;
               end else begin
                  count_d = count_q + COUNT_W'(1);
               end
            end
         end

         S_HIGH: begin
            if (!in_s) begin
               state_d = S_FALL;
               count_d = '0;
            end
         end

         S_FALL: begin
            if (in_s) begin
               // Bounce back high: abandon this candidate.
               state_d = S_HIGH;
               count_d = '0;
            end else if (bus.ena) begin
               if (count_q == COUNT_LAST) begin
                  state_d = S_LOW;
                  count_d = '0;
               end else begin
                  count_d = count_q + COUNT_W'(1);
               end
            end
         end

         // All four codes are in use; this arm keeps any corrupted value
         // (e.g. X in simulation) from sticking and returns to idle-low.
         default: begin
            state_d = S_LOW;
            count_d = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State and counter registers.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_LOW;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // --------------------------------------------------------------------------
   // Moore outputs, taken directly from the state register. Because the reset
   // is asynchronous, both drop to 0 the moment rst falls, without a clock.
   // --------------------------------------------------------------------------
   assign bus.out      = state_q[1];
   assign bus.bouncing = state_q[0];

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Purpose:
//    Self-checking bench for button_debouncer (BOUNCE_TICKS=4, 10 ns clock).
//    A reference model driven by the same inputs pushes the expected
//    {out, bouncing} for every clock edge into a queue; a monitor process
//    pops and compares after each edge. Directed scenarios additionally check
//    latencies and pulse shapes against fixed numbers, then a randomized
//    phase drives random levels, hold times and tick patterns.
//
// Reference model:
//    The synchronizer is a two-sample delay line. The debounced level flips
//    once the delayed input has disagreed with it on an unbroken run of edges
//    that contains BOUNCE_TICKS ena-high edges after the run's first edge;
//    the outputs show "bouncing" while such a run is open.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

   localparam int BT = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   button_debouncer_if bif ();

   button_debouncer #(
      .BOUNCE_TICKS (BT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Reference model: one expectation per clock edge out of reset.
   // --------------------------------------------------------------------------
   initial begin : ref_model
      logic hist[$];
      logic seen;
      logic out_m;
      logic bnc;
      int   run_len;
      int   ena_cnt;

      out_m   = 1'b0;
      run_len = 0;
      ena_cnt = 0;
      hist    = {1'b0, 1'b0};
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            out_m   = 1'b0;
            run_len = 0;
            ena_cnt = 0;
            hist    = {1'b0, 1'b0};
            exp_q.delete();
         end else begin
            seen = hist.pop_front();
            hist.push_back(bif.in);
            bnc = 1'b0;
            if (seen == out_m) begin
               run_len = 0;
               ena_cnt = 0;
            end else if (run_len == 0) begin
               run_len = 1;
               bnc     = 1'b1;
            end else begin
               if (bif.ena) ena_cnt++;
               if (ena_cnt >= BT) begin
                  out_m   = ~out_m;
                  run_len = 0;
                  ena_cnt = 0;
               end else begin
                  bnc = 1'b1;
               end
            end
            exp_q.push_back({out_m, bnc});
         end
      end
   end

   // --------------------------------------------------------------------------
   // Monitor: compares the DUT against the oldest expectation after each edge.
   // --------------------------------------------------------------------------
   initial begin : monitor
      logic [1:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sb_out", bif.out, e[1]);
               check("sb_bouncing", bif.bouncing, e[0]);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers. All start and end at a falling clock edge; bit k of a
   // pattern is sampled by edge k, bit k of a trace is the output after it.
   // --------------------------------------------------------------------------
   task automatic run_pattern(input logic [63:0] in_pat, input logic [63:0] ena_pat,
                              input int n, output logic [63:0] ot, output logic [63:0] bt);
      ot = '0;
      bt = '0;
      for (int k = 0; k < n; k++) begin
         bif.in  = in_pat[k];
         bif.ena = ena_pat[k];
         @(posedge clk);
         #1;
         ot[k] = bif.out;
         bt[k] = bif.bouncing;
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         bif.in  = 1'b0;
         bif.ena = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   function automatic int first_idx(input logic [63:0] tr, input int from, input int n, input logic v);
      for (int k = from; k < n; k++) begin
         if (tr[k] === v) return k;
      end
      return -1;
   endfunction

   function automatic int count_rises(input logic [63:0] tr, input int n);
      int   cnt  = 0;
      logic prev = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (tr[k] && !prev) cnt++;
         prev = tr[k];
      end
      return cnt;
   endfunction

   // --------------------------------------------------------------------------
   // Main sequence.
   // --------------------------------------------------------------------------
   initial begin : main
      logic [63:0] ot;
      logic [63:0] bt;
      logic [63:0] ena_pat;
      logic [27:0] all_ones;

      // Reset held with a busy input: outputs stay low on every edge.
      rst     = 1'b0;
      bif.in  = 1'b1;
      bif.ena = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         bif.in = ~bif.in;
         check("rst_hold_out", bif.out, 0);
         check("rst_hold_bouncing", bif.bouncing, 0);
      end
      @(negedge clk);
      bif.in = 1'b0;
      rst    = 1'b1;
      idle(6);

      // Clean press held 20 cycles, then release.
      run_pattern(64'h0000_0000_000F_FFFF, '1, 40, ot, bt);
      check("press_rise_edge", first_idx(ot, 0, 40, 1'b1), 6);
      check("press_bounce_window", bt[6:0], 7'h3C);
      check("release_fall_edge", first_idx(ot, 6, 40, 1'b0), 26);
      check("release_bounce_window", bt[26:20], 7'h3C);
      idle(4);

      // Four-cycle glitch is filtered; bouncing pulses four cycles.
      run_pattern(64'h0000_0000_0000_000F, '1, 16, ot, bt);
      check("glitch4_out", ot[15:0], 0);
      check("glitch4_bounce_len", $countones(bt[15:0]), 4);
      idle(4);

      // Five-cycle pulse passes: rises at 6, falls at 5+6.
      run_pattern(64'h0000_0000_0000_001F, '1, 20, ot, bt);
      check("pulse5_rise_edge", first_idx(ot, 0, 20, 1'b1), 6);
      check("pulse5_fall_edge", first_idx(ot, 6, 20, 1'b0), 11);
      idle(4);

      // Bounce train 1,0,1,0,1 every two cycles, then held high.
      run_pattern(64'h0000_0000_3FFF_FF33, '1, 30, ot, bt);
      check("train_quiet", ot[13:0], 0);
      check("train_rise_edge", first_idx(ot, 0, 30, 1'b1), 14);
      check("train_single_rise", count_rises(ot, 30), 1);

      // Asynchronous reset between edges while out is high.
      check("pre_async_rst_out", bif.out, 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_out", bif.out, 0);
      check("async_rst_bouncing", bif.bouncing, 0);
      @(negedge clk);
      bif.in = 1'b0;
      rst    = 1'b1;
      idle(4);

      // Tick one cycle in three: qualification needs four ticks in S_RISE.
      ena_pat = '0;
      for (int k = 0; k < 64; k += 3) ena_pat[k] = 1'b1;
      run_pattern('1, ena_pat, 30, ot, bt);
      check("ena_third_rise_edge", first_idx(ot, 0, 30, 1'b1), 12);
      run_pattern('0, '1, 12, ot, bt);
      check("ena_third_release", ot[11], 0);

      // Tick never asserted: stuck qualifying, out never moves.
      run_pattern('1, '0, 30, ot, bt);
      all_ones = '1;
      check("ena_off_out", ot[29:0], 0);
      check("ena_off_bouncing", bt[29:2], all_ones);
      run_pattern('0, '1, 8, ot, bt);
      idle(4);

      // Reset in S_RISE with count=2, then requalify from scratch.
      run_pattern('1, '1, 5, ot, bt);
      check("midq_bouncing", bif.bouncing, 1);
      #1;
      rst = 1'b0;
      #1;
      check("midq_rst_out", bif.out, 0);
      check("midq_rst_bouncing", bif.bouncing, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_pattern('1, '1, 12, ot, bt);
      check("midq_requal_rise_edge", first_idx(ot, 0, 12, 1'b1), 6);
      idle(4);

      // Randomized levels, hold times and tick patterns.
      for (int s = 0; s < 300; s++) begin
         logic lvl;
         int   len;
         int   mode;
         lvl  = 1'($urandom_range(0, 1));
         len  = $urandom_range(1, 9);
         mode = $urandom_range(0, 2);
         for (int k = 0; k < len; k++) begin
            bif.in  = lvl;
            bif.ena = (mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
         end
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_button_debouncer
